ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port word RAM between two requesters on one clock.
- Requester 0 is the CPU data port; requester 1 is a DMA/loader engine.
- Round-robin arbitration, optional bus lock for back-to-back bursts, bounded by a fairness counter.
- Drives the RAM address, write data and byte enables; returns registered read data with a valid strobe one cycle after grant.

Parameters:
- ADDR_W, 15, word-RAM byte-address width, passed straight through to ram_addr.
- MAX_LOCK, 8, maximum consecutive grants to one requester while the other is requesting (range 1..255).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- m0_req  input  1  requester 0 access request, held until granted.
- m0_addr  input  ADDR_W  requester 0 byte address.
- m0_wdata  input  32  requester 0 write data.
- m0_wstrb  input  4  requester 0 byte write enables; 0 means read.
- m0_lock  input  1  requester 0 asks to keep the bus after this grant.
- m0_gnt  output  1  requester 0 access performed this cycle.
- m0_rdata  output  32  requester 0 read data.
- m0_rvalid  output  1  m0_rdata valid, one-cycle pulse.
- m1_req, m1_addr, m1_wdata, m1_wstrb, m1_lock, m1_gnt, m1_rdata, m1_rvalid: same as the m0_* ports, for requester 1.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  32  RAM write data.
- ram_wenable  output  4  RAM byte write enables.
- ram_rdata  input  32  RAM read data, asynchronous (valid in the same cycle as ram_addr).

Behaviour:
- Reset (async, rst_n=0):
  - gnt outputs 0, rvalid outputs 0, rdata outputs 32'h0.
  - State IDLE, last-granted pointer = 1 (requester 0 wins first), lock counter 0.
  - ram_wenable forced to 0 while reset is asserted.
- Grants are combinational from the req inputs and registered state.
  - At most one gnt is high per cycle.
  - A granted access completes in that same cycle:
    - write: ram_wenable = granted wstrb, committed at the cycle-ending edge;
    - read: ram_rdata is captured at the same edge.
- Read latency: a read granted in cycle T gives rdata/rvalid in cycle T+1.
  - rvalid is high for exactly one cycle.
  - A write grant never raises rvalid.
  - rdata holds its last value when rvalid is low.
- Unselected mux: with no grant, ram_addr/ram_wdata follow requester 0 and ram_wenable = 0.
- States:
  - IDLE: no owner.
    - Both requesting: grant the requester that is not the last-granted one.
    - One requesting: grant it.
    - If the granted requester's lock is high, go to OWN0 or OWN1 with counter = 1.
  - OWNx: requester x has priority.
    - If req_x is high, grant x and increment the counter.
    - Leave to IDLE when req_x is low or lock_x is low on a grant.
    - Leave when the counter has reached MAX_LOCK and the other requester is requesting; that cycle grants the other requester instead (forced switch).
    - If the other requester is idle, the counter saturates at MAX_LOCK and the lock is kept.
- The last-granted pointer updates on every grant.
- Counter is 8 bits and never wraps.
- Addresses pass through unmodified; no decode or range check.
- A req that drops before being granted is legal; no state changes.
- Reset mid-read: the pending rvalid is lost, and neither rvalid pulses after reset release.

Test Plan:
- Reset, then m0 reads 0x0010 holding 32'hDEADBEEF:
  - m0_gnt high in cycle 0;
  - m0_rvalid high with m0_rdata=32'hDEADBEEF in cycle 1 only.
- m0 and m1 both issue unlocked reads continuously for 4 cycles:
  - grants alternate m0, m1, m0, m1;
  - never both high.
- m1 writes 32'h12345678 with wstrb=4'b0011 to 0x0020 holding 0:
  - readback by m0 returns 32'h00005678;
  - m1_rvalid stays 0.
- m1 locked with m0 idle for 20 cycles:
  - m1 granted all 20 cycles;
  - m0 then requests while m1 stays locked: m0 granted in the next cycle (counter already at MAX_LOCK=8), then arbitration returns to m1.
- m0 locked from IDLE, m1 requesting throughout, MAX_LOCK=8:
  - m0 granted exactly 8 consecutive cycles;
  - 9th cycle grants m1.
- Assert rst_n=0 in the cycle after a granted read:
  - m0_rvalid 0 immediately;
  - stays 0 after release;
  - first grant after release goes to m0 when both are requesting.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port word RAM between a CPU data port (m0)
// and a DMA/loader engine (m1). Round-robin arbitration with an optional bus
// lock for back-to-back bursts. While the other side is waiting, a lock is
// bounded to MAX_LOCK consecutive grants. Read data returns registered, one
// cycle after the grant.
module ram_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic [31:0]       m0_rdata,
  output logic              m0_rvalid,

  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic [31:0]       m1_rdata,
  output logic              m1_rvalid,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wenable,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  state_e      state_q, state_d;
  logic        last_q, last_d;     // requester granted most recently
  logic [7:0]  cnt_q, cnt_d;       // consecutive grants to the current owner

  logic        own_sel;            // which requester owns the bus in OWNx
  logic        own_req;
  logic        oth_req;
  logic        own_lock;
  logic        grant_any;
  logic        grant_sel;          // 0 = m0, 1 = m1 (meaningful when grant_any)

  logic        m0_rd, m1_rd;       // a read is being performed this cycle

  logic        m0_rvalid_q, m1_rvalid_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  // Arbitration: pick this cycle's grant and the next arbiter state.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant_any = 1'b0;
    grant_sel = 1'b0;
    own_sel   = (state_q == OWN1);
    own_req   = own_sel ? m1_req  : m0_req;
    oth_req   = own_sel ? m0_req  : m1_req;
    own_lock  = own_sel ? m1_lock : m0_lock;

    if ((state_q != IDLE) && own_req) begin
      grant_any = 1'b1;
      if ((cnt_q >= LOCK_MAX) && oth_req) begin
        // Fairness bound reached with the other side waiting: hand it the
        // bus for this cycle and drop back to round-robin.
        grant_sel = ~own_sel;
        state_d   = IDLE;
        cnt_d     = 8'd0;
      end else begin
        grant_sel = own_sel;
        if (own_lock) begin
          // Saturates rather than wraps so an uncontested lock never
          // loses its bound.
          cnt_d = (cnt_q >= LOCK_MAX) ? LOCK_MAX : cnt_q + 8'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
    end else begin
      // No owner (or the owner dropped its request): plain round-robin.
      state_d = IDLE;
      cnt_d   = 8'd0;
      if (m0_req || m1_req) begin
        grant_any = 1'b1;
        grant_sel = (m0_req && m1_req) ? ~last_q : m1_req;
        if (grant_sel ? m1_lock : m0_lock) begin
          state_d = grant_sel ? OWN1 : OWN0;
          cnt_d   = 8'd1;
        end
      end
    end

    if (grant_any) begin
      last_d = grant_sel;
    end
  end

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  assign m0_gnt = rst_n & grant_any & ~grant_sel;
  assign m1_gnt = rst_n & grant_any &  grant_sel;

  // RAM mux: requester 0 is the default path when nobody is granted.
  assign ram_addr    = m1_gnt ? m1_addr  : m0_addr;
  assign ram_wdata   = m1_gnt ? m1_wdata : m0_wdata;
  assign ram_wenable = m0_gnt ? m0_wstrb : (m1_gnt ? m1_wstrb : 4'h0);

  assign m0_rd = m0_gnt && (m0_wstrb == 4'h0);
  assign m1_rd = m1_gnt && (m1_wstrb == 4'h0);

  // Arbiter state register; requester 0 wins the first contested cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read return: capture RAM data at the grant edge, pulse valid one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
    end else begin
      m0_rvalid_q <= m0_rd;
      m1_rvalid_q <= m1_rd;
      if (m0_rd) begin
        m0_rdata_q <= ram_rdata;
      end
      if (m1_rd) begin
        m1_rdata_q <= ram_rdata;
      end
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a small word RAM in the environment, a behavioural
// arbitration/memory model, directed scenarios and a randomized run.
module tb_ram_arbiter;

  localparam int ADDR_W   = 15;
  localparam int MAX_LOCK = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              req   [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [31:0]       wdata [2];
  logic [3:0]        wstrb [2];
  logic              lock  [2];

  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]       m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wenable;
  logic [31:0]       ram_rdata;

  ram_arbiter #(.ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]),
    .m0_lock(lock[0]), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]),
    .m1_lock(lock[1]), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wenable(ram_wenable),
    .ram_rdata(ram_rdata)
  );

  // Environment RAM: 64 words, indexed by byte address bits [7:2].
  logic [31:0] mem [64];
  logic        clr, pre_en;
  assign ram_rdata = mem[ram_addr[7:2]];

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    if (pre_en) mem[4] <= 32'hDEADBEEF;
    for (int b = 0; b < 4; b++)
      if (ram_wenable[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
  end

  // Behavioural model state
  int          m_owner;   // -1 none, else requester holding a lock
  int          m_cnt;
  int          m_last;
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];
  logic [31:0] ref_mem [64];

  int          obs_g;
  logic        obs_rv [2];
  logic [31:0] obs_rd [2];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; lock[i] = 1'b0; wstrb[i] = 4'h0; addr[i] = '0; wdata[i] = 32'h0;
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 1;
    for (int i = 0; i < 2; i++) begin exp_rv[i] = 1'b0; exp_rd[i] = 32'h0; end
  endtask

  // One clock cycle: inputs are already applied; check at the falling edge,
  // then advance the model and step past the rising edge.
  task automatic cycle();
    int g;
    int o;
    logic [3:0] we;
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    g = -1;
    if (m_owner >= 0 && req[m_owner]) begin
      o = m_owner;
      if (m_cnt >= MAX_LOCK && req[1-o]) begin
        g = 1 - o; m_owner = -1; m_cnt = 0;
      end else begin
        g = o;
        if (lock[o]) m_cnt = (m_cnt + 1 > MAX_LOCK) ? MAX_LOCK : m_cnt + 1;
        else begin m_owner = -1; m_cnt = 0; end
      end
    end else begin
      m_owner = -1; m_cnt = 0;
      if (req[0] && req[1]) g = 1 - m_last;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
      if (g >= 0 && lock[g]) begin m_owner = g; m_cnt = 1; end
    end
    if (g >= 0) m_last = g;

    we = (g >= 0) ? wstrb[g] : 4'h0;
    ea = (g == 1) ? addr[1] : addr[0];
    chk("m0_gnt", m0_gnt, g == 0);
    chk("m1_gnt", m1_gnt, g == 1);
    chk("both_gnt", m0_gnt & m1_gnt, 0);
    chk("ram_addr", ram_addr, ea);
    chk("ram_wenable", ram_wenable, we);
    if (we != 4'h0) chk("ram_wdata", ram_wdata, wdata[g]);
    chk("m0_rvalid", m0_rvalid, exp_rv[0]);
    chk("m1_rvalid", m1_rvalid, exp_rv[1]);
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);

    obs_g = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
    obs_rv[0] = m0_rvalid; obs_rv[1] = m1_rvalid;
    obs_rd[0] = m0_rdata;  obs_rd[1] = m1_rdata;

    for (int i = 0; i < 2; i++) begin
      exp_rv[i] = (g == i) && (wstrb[i] == 4'h0);
      if (exp_rv[i]) exp_rd[i] = ref_mem[addr[i][7:2]];
    end
    if (g >= 0)
      for (int b = 0; b < 4; b++)
        if (wstrb[g][b]) ref_mem[addr[g][7:2]][b*8 +: 8] = wdata[g][b*8 +: 8];

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit preload);
    rst_n = 1'b0; clr = 1'b1; pre_en = preload;
    set_idle();
    req[0] = 1'b1; req[1] = 1'b1; wstrb[1] = 4'hF;
    @(posedge clk); #1;
    clr = 1'b0; pre_en = 1'b0;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_wenable", ram_wenable, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    @(posedge clk); #1;
    set_idle();
    model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    if (preload) ref_mem[4] = 32'hDEADBEEF;
    rst_n = 1'b1;
  endtask

  int seq [16];
  int run;

  initial begin
    clr = 1'b0; pre_en = 1'b0;
    set_idle();
    model_reset();

    // Single read of a preloaded word
    do_reset(1'b1);
    req[0] = 1'b1; addr[0] = 15'h0010;
    cycle();
    chk("t1_gnt", obs_g, 0);
    req[0] = 1'b0;
    cycle();
    chk("t1_rvalid", obs_rv[0], 1);
    chk("t1_rdata", obs_rd[0], 32'hDEADBEEF);
    cycle();
    chk("t1_rvalid_end", obs_rv[0], 0);

    // Contended unlocked reads alternate, starting with m0
    do_reset(1'b0);
    req[0] = 1'b1; req[1] = 1'b1; addr[0] = 15'h0004; addr[1] = 15'h0008;
    for (int k = 0; k < 4; k++) begin
      cycle();
      seq[k] = obs_g;
    end
    for (int k = 0; k < 4; k++) chk("t2_alternate", seq[k], k % 2);
    set_idle();
    cycle();

    // Partial write by m1, readback by m0
    req[1] = 1'b1; addr[1] = 15'h0020; wdata[1] = 32'h12345678; wstrb[1] = 4'b0011;
    cycle();
    chk("t3_wr_gnt", obs_g, 1);
    set_idle();
    req[0] = 1'b1; addr[0] = 15'h0020;
    cycle();
    chk("t3_m1_rvalid", obs_rv[1], 0);
    chk("t3_rd_gnt", obs_g, 0);
    set_idle();
    cycle();
    chk("t3_rvalid", obs_rv[0], 1);
    chk("t3_rdata", obs_rd[0], 32'h00005678);
    chk("t3_m1_rvalid2", obs_rv[1], 0);

    // m1 locked alone for 20 cycles, then m0 cuts in once
    req[1] = 1'b1; lock[1] = 1'b1; addr[1] = 15'h0040;
    run = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (obs_g == 1) run++;
    end
    chk("t4_m1_run", run, 20);
    req[0] = 1'b1; addr[0] = 15'h0044;
    cycle();
    chk("t4_forced_m0", obs_g, 0);
    req[0] = 1'b0;
    cycle();
    chk("t4_back_m1", obs_g, 1);
    set_idle();
    cycle();

    // m0 locked from IDLE against a waiting m1
    req[0] = 1'b1; lock[0] = 1'b1; req[1] = 1'b1; addr[0] = 15'h0010; addr[1] = 15'h0014;
    for (int k = 0; k < 9; k++) begin
      cycle();
      seq[k] = obs_g;
    end
    run = 0;
    for (int k = 0; k < 9; k++) begin
      if (seq[k] != 0) break;
      run++;
    end
    chk("t5_m0_run", run, MAX_LOCK);
    chk("t5_ninth", seq[8], 1);
    set_idle();
    cycle();

    // Reset while a read response is pending
    do_reset(1'b1);
    req[0] = 1'b1; addr[0] = 15'h0010;
    cycle();
    chk("t6_gnt", obs_g, 0);
    rst_n = 1'b0;
    req[1] = 1'b1; wstrb[1] = 4'hF;
    #1;
    chk("t6_rvalid_now", m0_rvalid, 0);
    chk("t6_wenable", ram_wenable, 0);
    model_reset();
    @(posedge clk); #1;
    set_idle();
    req[0] = 1'b1; req[1] = 1'b1; addr[0] = 15'h0010; addr[1] = 15'h0018;
    rst_n = 1'b1;
    cycle();
    chk("t6_first_gnt", obs_g, 0);
    chk("t6_rvalid_after", obs_rv[0], 0);
    chk("t6_m1_rvalid_after", obs_rv[1], 0);
    set_idle();
    cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        req[i]   = ($urandom_range(0, 3) != 0);
        lock[i]  = ($urandom_range(0, 2) != 0);
        addr[i]  = ADDR_W'($urandom);
        wdata[i] = $urandom;
        wstrb[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      cycle();
    end
    set_idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
